rob_alloc_ctrl: RTL and testbench
=================================

Name: rob_alloc_ctrl

Overview:
- Dispatch-side controller that sequences the decode/ID pipeline register and allocates reorder-buffer (ROB) entries in program order.
- Owns the ROB head/tail pointers and the occupancy count, and supplies the allocated tag to the decoder.
- Generates id_stall/id_flush for the ID register and a post-flush recovery window during which RAT restoration completes.

Parameters:
- ROB_DEPTH, 8, number of ROB entries; power of two, >= 2.
- RECOVER_CYCLES, 2, stall cycles after a flush before dispatch resumes; >= 1.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- cpu_en  input  1  global enable; when low, all state holds.
- dispatch_valid  input  1  decoded instruction present and requests a ROB entry.
- rs_full  input  1  reservation stations cannot accept an instruction.
- commit_valid  input  1  ROB head retires this cycle.
- flush_req  input  1  mispredict/exception; squash all uncommitted entries.
- alloc_rob  output  $clog2(ROB_DEPTH)  tag for the current dispatch; equals tail.
- alloc_fire  output  1  entry allocated this cycle.
- commit_rob  output  $clog2(ROB_DEPTH)  current head tag.
- id_stall  output  1  hold the ID register.
- id_flush  output  1  clear the ID register.
- rob_count  output  $clog2(ROB_DEPTH)+1  occupied entries.
- rob_full  output  1  rob_count == ROB_DEPTH.
- rob_empty  output  1  rob_count == 0.
- recovering  output  1  state == RECOVER.
- commit_err  output  1  sticky; commit_valid seen while empty.

Behaviour:
- Reset (async, rst_n low):
  - head = 0, tail = 0, count = 0, state = RUN, recover counter = 0, commit_err = 0.
  - Resulting outputs: alloc_rob = 0, commit_rob = 0, rob_empty = 1, rob_full = 0, id_stall = 0, id_flush = 0, alloc_fire = 0, recovering = 0.
  - Reset may arrive mid-recovery or mid-operation; it always returns to this state.
- Combinational outputs, from current state only:
  - alloc_rob = tail; commit_rob = head.
  - id_flush = flush_req.
  - id_stall = recovering | rob_full | rs_full.
  - alloc_fire = cpu_en & dispatch_valid & state==RUN & !rob_full & !rs_full & !flush_req.
- A commit in the same cycle does NOT free space for a same-cycle allocation; rob_full uses the registered count.
- cpu_en low: no register updates; alloc_fire = 0.
- Per clock edge, when cpu_en is high:
  - Effective commit (ce) = commit_valid & !rob_empty.
  - commit_valid while empty: ignored; sets commit_err, which stays set until reset.
  - ce: head <= head+1, modulo ROB_DEPTH (natural wrap).
  - Without flush: alloc_fire advances tail by 1 (wrap). count <= count + alloc_fire - ce; simultaneous alloc and commit leaves count unchanged.
  - With flush_req: the same-cycle commit is honoured, then tail <= new head and count <= 0. No allocation occurs. state <= RECOVER and the recover counter loads RECOVER_CYCLES-1.
- State machine:
  - RUN: on flush_req go to RECOVER; otherwise stay in RUN.
  - RECOVER: while the counter != 0, decrement it. When the counter is 0, go to RUN at the next edge.
  - flush_req during RECOVER reloads the counter and stays in RECOVER.
  - RECOVER therefore lasts exactly RECOVER_CYCLES cycles after the flush cycle; commits are still accepted during it.
- Invariant: tail - head modulo ROB_DEPTH == count modulo ROB_DEPTH. When full, head == tail and count == ROB_DEPTH.

Test Plan:
- Reset, then dispatch_valid=1 for 10 cycles with no commits (ROB_DEPTH=8): alloc_rob steps 0..7 with alloc_fire=1; cycle 9 shows rob_full=1, id_stall=1, alloc_fire=0, and count holds at 8.
- From full, commit_valid=1 with dispatch_valid=1 for 1 cycle: count 8->7 with no allocation that cycle. Next cycle alloc_fire=1, tail wraps 0->1, count returns to 8.
- Count=3 (head=2, tail=5), flush_req with commit_valid in the same cycle: id_flush=1 that cycle. Next cycle head=3, tail=3, count=0, recovering=1, id_stall=1 for exactly 2 cycles, then dispatch allocates tag 3.
- rs_full=1 with dispatch_valid=1 and count=2: id_stall=1, alloc_fire=0, pointers unchanged. Dropping rs_full gives alloc_fire=1 the next cycle.
- commit_valid=1 with rob_empty=1: head unchanged, count stays 0, commit_err=1 and remains set after 5 further idle cycles.
- cpu_en=0 for 3 cycles during RECOVER with dispatch/commit active: no pointer, count or counter change. Recovery completes only after cpu_en returns. Asserting rst_n=0 mid-recovery yields RUN with all zero pointers.

Source files
------------

// File: rtl/rob_alloc_ctrl.sv
// rob_alloc_ctrl: dispatch-side controller for the decode/ID register.
// It allocates reorder-buffer entries in program order, tracks the head,
// tail and occupancy, and holds dispatch off for a short recovery window
// after a flush while the rename table is being restored.
module rob_alloc_ctrl #(
  parameter int ROB_DEPTH      = 8,
  parameter int RECOVER_CYCLES = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cpu_en,
  input  logic                         dispatch_valid,
  input  logic                         rs_full,
  input  logic                         commit_valid,
  input  logic                         flush_req,
  output logic [$clog2(ROB_DEPTH)-1:0] alloc_rob,
  output logic                         alloc_fire,
  output logic [$clog2(ROB_DEPTH)-1:0] commit_rob,
  output logic                         id_stall,
  output logic                         id_flush,
  output logic [$clog2(ROB_DEPTH):0]   rob_count,
  output logic                         rob_full,
  output logic                         rob_empty,
  output logic                         recovering,
  output logic                         commit_err
);

  localparam int AW  = $clog2(ROB_DEPTH);
  localparam int CW  = AW + 1;
  localparam int RCW = (RECOVER_CYCLES > 1) ? $clog2(RECOVER_CYCLES) : 1;
  localparam logic [RCW-1:0] RC_LOAD = RCW'(RECOVER_CYCLES - 1);

  typedef enum logic {RUN, RECOVER} state_t;

  state_t          state, state_next;
  logic [RCW-1:0]  rec_cnt, rec_cnt_next;
  logic [AW-1:0]   head, tail, head_next;
  logic [CW-1:0]   count;
  logic            ce;

  // State register for the recovery sequencer; frozen while cpu_en is low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RUN;
      rec_cnt <= '0;
    end else if (cpu_en) begin
      state   <= state_next;
      rec_cnt <= rec_cnt_next;
    end
  end

  // Next-state logic: a flush (re)arms the recovery countdown from either state
  always_comb begin
    state_next   = state;
    rec_cnt_next = rec_cnt;
    case (state)
      RUN: begin
        if (flush_req) begin
          state_next   = RECOVER;
          rec_cnt_next = RC_LOAD;
        end
      end
      RECOVER: begin
        if (flush_req) begin
          rec_cnt_next = RC_LOAD;
        end else if (rec_cnt != '0) begin
          rec_cnt_next = rec_cnt - RCW'(1);
        end else begin
          state_next = RUN;
        end
      end
      default: begin
        state_next   = RUN;
        rec_cnt_next = '0;
      end
    endcase
  end

  // Output logic: everything here depends only on registered state and live inputs,
  // so a same-cycle commit never makes room for a same-cycle allocation
  always_comb begin
    recovering = (state == RECOVER);
    rob_count  = count;
    rob_full   = (count == CW'(ROB_DEPTH));
    rob_empty  = (count == '0);
    alloc_rob  = tail;
    commit_rob = head;
    id_flush   = flush_req;
    id_stall   = recovering | rob_full | rs_full;
    alloc_fire = cpu_en & dispatch_valid & (state == RUN) & ~rob_full & ~rs_full & ~flush_req;
    ce         = commit_valid & ~rob_empty;
    head_next  = head + AW'(ce);
  end

  // Pointer and occupancy update; a flush squashes everything younger than the new head
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      commit_err <= 1'b0;
    end else if (cpu_en) begin
      head       <= head_next;
      commit_err <= commit_err | (commit_valid & rob_empty);
      if (flush_req) begin
        tail  <= head_next;
        count <= '0;
      end else begin
        tail  <= tail + AW'(alloc_fire);
        count <= count + CW'(alloc_fire) - CW'(ce);
      end
    end
  end

endmodule

// File: tb/tb_rob_alloc_ctrl.sv
// tb_rob_alloc_ctrl: vector-table bench for rob_alloc_ctrl (ROB_DEPTH=8,
// RECOVER_CYCLES=2). Each record holds the inputs for one cycle and the
// outputs expected during that cycle; expectations go through a queue.
module tb_rob_alloc_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cpu_en = 1'b0;
  logic       dispatch_valid = 1'b0;
  logic       rs_full = 1'b0;
  logic       commit_valid = 1'b0;
  logic       flush_req = 1'b0;
  logic [2:0] alloc_rob;
  logic       alloc_fire;
  logic [2:0] commit_rob;
  logic       id_stall;
  logic       id_flush;
  logic [3:0] rob_count;
  logic       rob_full;
  logic       rob_empty;
  logic       recovering;
  logic       commit_err;

  rob_alloc_ctrl #(.ROB_DEPTH(8), .RECOVER_CYCLES(2)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cpu_en         (cpu_en),
    .dispatch_valid (dispatch_valid),
    .rs_full        (rs_full),
    .commit_valid   (commit_valid),
    .flush_req      (flush_req),
    .alloc_rob      (alloc_rob),
    .alloc_fire     (alloc_fire),
    .commit_rob     (commit_rob),
    .id_stall       (id_stall),
    .id_flush       (id_flush),
    .rob_count      (rob_count),
    .rob_full       (rob_full),
    .rob_empty      (rob_empty),
    .recovering     (recovering),
    .commit_err     (commit_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit rst, en, dv, rsf, cv, fl;
    int tail, head, cnt;
    bit fire, stall, flsh, rec, err;
  } vec_t;

  typedef struct {
    int tail, head, cnt;
    bit fire, stall, flsh, rec, err, full, empty;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   vec_idx = 0;

  function automatic vec_t mk(input bit rst, en, dv, rsf, cv, fl,
                              input int tail, head, cnt,
                              input bit fire, stall, flsh, rec, err);
    vec_t v;
    v.rst = rst; v.en = en; v.dv = dv; v.rsf = rsf; v.cv = cv; v.fl = fl;
    v.tail = tail; v.head = head; v.cnt = cnt;
    v.fire = fire; v.stall = stall; v.flsh = flsh; v.rec = rec; v.err = err;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    exp_t e;
    if (v.rst) begin
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
    end
    cpu_en         = v.en;
    dispatch_valid = v.dv;
    rs_full        = v.rsf;
    commit_valid   = v.cv;
    flush_req      = v.fl;
    e.tail  = v.tail;  e.head = v.head; e.cnt = v.cnt;
    e.fire  = v.fire;  e.stall = v.stall; e.flsh = v.flsh;
    e.rec   = v.rec;   e.err = v.err;
    e.full  = (v.cnt == 8);
    e.empty = (v.cnt == 0);
    sb.push_back(e);
  endtask

  task automatic cmp(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("[TB] FAIL vec%0d %s: got %0d expected %0d", vec_idx, name, act, req);
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL vec%0d scoreboard: got empty queue expected entry", vec_idx);
      return;
    end
    e = sb.pop_front();
    cmp("alloc_rob",  int'(alloc_rob),  e.tail);
    cmp("commit_rob", int'(commit_rob), e.head);
    cmp("rob_count",  int'(rob_count),  e.cnt);
    cmp("alloc_fire", int'(alloc_fire), int'(e.fire));
    cmp("id_stall",   int'(id_stall),   int'(e.stall));
    cmp("id_flush",   int'(id_flush),   int'(e.flsh));
    cmp("recovering", int'(recovering), int'(e.rec));
    cmp("commit_err", int'(commit_err), int'(e.err));
    cmp("rob_full",   int'(rob_full),   int'(e.full));
    cmp("rob_empty",  int'(rob_empty),  int'(e.empty));
  endtask

  initial begin
    // Fill to full, keep requesting, then commit+dispatch from full
    vecs.push_back(mk(1,1,1,0,0,0, 0,0,0, 1,0,0,0,0));
    for (int k = 1; k < 8; k++) vecs.push_back(mk(0,1,1,0,0,0, k,0,k, 1,0,0,0,0));
    vecs.push_back(mk(0,1,1,0,0,0, 0,0,8, 0,1,0,0,0));
    vecs.push_back(mk(0,1,1,0,0,0, 0,0,8, 0,1,0,0,0));
    vecs.push_back(mk(0,1,1,0,1,0, 0,0,8, 0,1,0,0,0));
    vecs.push_back(mk(0,1,1,0,0,0, 0,1,7, 1,0,0,0,0));
    vecs.push_back(mk(0,1,0,0,0,0, 1,1,8, 0,1,0,0,0));
    // Flush with a same-cycle commit at head=2 tail=5, then two recovery cycles
    vecs.push_back(mk(1,1,1,0,0,0, 0,0,0, 1,0,0,0,0));
    for (int k = 1; k < 5; k++) vecs.push_back(mk(0,1,1,0,0,0, k,0,k, 1,0,0,0,0));
    vecs.push_back(mk(0,1,0,0,1,0, 5,0,5, 0,0,0,0,0));
    vecs.push_back(mk(0,1,0,0,1,0, 5,1,4, 0,0,0,0,0));
    vecs.push_back(mk(0,1,1,0,1,1, 5,2,3, 0,0,1,0,0));
    vecs.push_back(mk(0,1,1,0,0,0, 3,3,0, 0,1,0,1,0));
    vecs.push_back(mk(0,1,1,0,0,0, 3,3,0, 0,1,0,1,0));
    vecs.push_back(mk(0,1,1,0,0,0, 3,3,0, 1,0,0,0,0));
    vecs.push_back(mk(0,1,0,0,0,0, 4,3,1, 0,0,0,0,0));
    // Reservation stations full blocks allocation
    vecs.push_back(mk(1,1,1,0,0,0, 0,0,0, 1,0,0,0,0));
    vecs.push_back(mk(0,1,1,0,0,0, 1,0,1, 1,0,0,0,0));
    vecs.push_back(mk(0,1,1,1,0,0, 2,0,2, 0,1,0,0,0));
    vecs.push_back(mk(0,1,1,1,0,0, 2,0,2, 0,1,0,0,0));
    vecs.push_back(mk(0,1,1,0,0,0, 2,0,2, 1,0,0,0,0));
    vecs.push_back(mk(0,1,0,0,0,0, 3,0,3, 0,0,0,0,0));
    // Commit while empty sets a sticky error
    vecs.push_back(mk(1,1,0,0,1,0, 0,0,0, 0,0,0,0,0));
    for (int k = 0; k < 6; k++) vecs.push_back(mk(0,1,0,0,0,0, 0,0,0, 0,0,0,0,1));
    // cpu_en low freezes recovery; reset mid-recovery returns to RUN
    vecs.push_back(mk(1,1,1,0,0,0, 0,0,0, 1,0,0,0,0));
    vecs.push_back(mk(0,1,1,0,0,0, 1,0,1, 1,0,0,0,0));
    vecs.push_back(mk(0,1,0,0,1,1, 2,0,2, 0,0,1,0,0));
    for (int k = 0; k < 3; k++) vecs.push_back(mk(0,0,1,0,1,0, 1,1,0, 0,1,0,1,0));
    vecs.push_back(mk(0,1,0,0,0,0, 1,1,0, 0,1,0,1,0));
    vecs.push_back(mk(0,1,0,0,0,0, 1,1,0, 0,1,0,1,0));
    vecs.push_back(mk(0,1,1,0,0,0, 1,1,0, 1,0,0,0,0));
    vecs.push_back(mk(0,1,0,0,0,1, 2,1,1, 0,0,1,0,0));
    vecs.push_back(mk(1,1,0,0,0,0, 0,0,0, 0,0,0,0,0));
    vecs.push_back(mk(0,1,1,0,0,0, 0,0,0, 1,0,0,0,0));
    // Flush during recovery reloads the countdown
    vecs.push_back(mk(1,1,1,0,0,0, 0,0,0, 1,0,0,0,0));
    vecs.push_back(mk(0,1,0,0,0,1, 1,0,1, 0,0,1,0,0));
    vecs.push_back(mk(0,1,0,0,0,0, 0,0,0, 0,1,0,1,0));
    vecs.push_back(mk(0,1,0,0,0,1, 0,0,0, 0,1,1,1,0));
    vecs.push_back(mk(0,1,0,0,0,0, 0,0,0, 0,1,0,1,0));
    vecs.push_back(mk(0,1,0,0,0,0, 0,0,0, 0,1,0,1,0));
    vecs.push_back(mk(0,1,1,0,0,0, 0,0,0, 1,0,0,0,0));

    repeat (2) @(posedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      vec_idx = i;
      @(posedge clk);
      #1;
      applyStimulus(vecs[i]);
      @(negedge clk);
      checkOutput();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
